// File: rtl/console_uart_tx.sv
// Console UART transmitter: bus-written TX FIFO feeding an 8N1 serializer.
// Optional macro CONSOLE_UART_SIM_PRINT_EN echoes accepted bytes to the simulation console.
module console_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic full, empty, wr_txdata, wr_status, push, pop, baud_tc;
    logic unused_wdata;

    assign unused_wdata = ^wdata[31:8];

    always_comb begin
        full      = (count_q == FULL_CNT);
        empty     = (count_q == '0);
        wr_txdata = sel && we && (addr == 4'h0);
        wr_status = sel && we && (addr == 4'h4);
        // fullness is judged on the pre-edge count, so a same-cycle pop never makes room
        push      = wr_txdata && !full;
        baud_tc   = (baud_q == '0);

        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_mem[rd_ptr_q];
                    state_d = START;
                    tx_d    = 1'b0;
                    baud_d  = BAUD_LOAD;
                end
            end
            START: begin
                if (baud_tc) begin
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                    bit_d   = 3'd0;
                    baud_d  = BAUD_LOAD;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            DATA: begin
                if (baud_tc) begin
                    baud_d = BAUD_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shreg_q[1];
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            STOP: begin
                if (baud_tc) begin
                    // chain straight into the next start bit when more bytes are waiting
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_mem[rd_ptr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                        baud_d  = BAUD_LOAD;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

        ovf_d = ovf_q;
        if (wr_txdata && full) begin
            ovf_d = 1'b1;
        end else if (wr_status && wdata[3]) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wdata[7:0];
        end
    end

`ifdef CONSOLE_UART_SIM_PRINT_EN
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            $write("%c", wdata[7:0]);
        end
    end
`else
`endif

    assign tx   = tx_q;
    assign busy = (state_q != IDLE) || !empty;

    always_comb begin
        rdata = '0;
        if (sel && !we && (addr == 4'h4)) begin
            rdata = {28'b0, ovf_q, busy, empty, full};
        end
    end

endmodule

// File: doc/console_uart_tx.md
CONSOLE_UART_TX -- requirements
Module: console_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200 baud); legal range 4 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries; power of two, 2 or more.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port sel  input  1  bus access strobe, one cycle per access.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; meaningful only with sel.
REQ-007 SHALL have port addr  input  4  byte offset: 0x0 TXDATA, 0x4 STATUS.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  read data, combinational.
REQ-010 SHALL have port tx  output  1  serial line, 8N1, LSB first, idle high, registered.
REQ-011 SHALL have port busy  output  1  high while FIFO non-empty or frame in flight.

Function
REQ-012 Write to TXDATA: push wdata[7:0] into FIFO at that edge if FIFO not full.
REQ-013 Write to TXDATA while full: byte dropped, FIFO unchanged, sticky overflow flag set. Fullness uses the pre-edge count, so a same-cycle pop does not make room.
REQ-014 Read STATUS: rdata = {28'b0, overflow, busy, empty, full} (bits 3..0).
REQ-015 Read TXDATA or any unmapped address: rdata = 0. Writes to unmapped addresses are ignored. rdata = 0 whenever sel = 0 or we = 1.
REQ-016 Write to STATUS with wdata[3] = 1: clear overflow. Other STATUS bits are read-only. If a clear and an overflow occur in the same cycle, overflow ends set.
REQ-017 FSM states are IDLE, START, DATA, STOP.
REQ-018 IDLE with FIFO non-empty: pop head into shift register, go to START. tx = 0 from the following edge.
REQ-019 START, DATA and STOP each hold tx for exactly CLKS_PER_BIT cycles per bit. DATA shifts 8 bits, bit 0 first. STOP drives tx = 1.
REQ-020 End of STOP with FIFO non-empty: pop and go directly to START, with no idle cycle between frames. End of STOP with FIFO empty: go to IDLE.
REQ-021 Latency: TXDATA write at edge N into an empty FIFO with FSM in IDLE gives tx low after edge N+1.
REQ-022 Frame length: 10*CLKS_PER_BIT cycles.
REQ-023 FIFO pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
REQ-024 A same-cycle push and pop on a non-full FIFO both take effect, and count is unchanged.
REQ-025 busy = 0 only in IDLE with the FIFO empty.

Reset
REQ-026 rst_n low immediately forces: tx = 1, FSM = IDLE, FIFO empty, overflow = 0, bit and baud counters = 0. busy = 0 and rdata = 0 as a consequence.
REQ-027 A reset asserted mid-frame aborts the frame and discards queued bytes. The line returns high without a glitch low.
REQ-028 Reset release is used directly. The first TXDATA write after release obeys REQ-021.

Configuration
REQ-029 Macro CONSOLE_UART_SIM_PRINT_EN defined: on every accepted TXDATA push, the simulation console prints the byte as a character with no newline added. Dropped bytes are not printed.
REQ-030 Macro undefined: no simulation print code is compiled. Serial and bus behaviour are identical in both builds.

Verification (CLKS_PER_BIT = 4, FIFO_DEPTH = 4 unless stated)
REQ-031 Single byte: write 0x55 at edge N -> tx low after N+1. Bit pattern is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. tx high and busy = 0 after 40 cycles.
REQ-032 Back-to-back: write "Hi" (0x48, 0x69) on consecutive cycles -> two frames, 80 cycles total, with no idle cycle between them. A line decoder recovers 0x48 then 0x69.
REQ-033 Overflow: 6 writes in 6 consecutive cycles starting from idle -> the first byte is popped, so 5 bytes are sent and 1 is dropped. STATUS reads 0x8|busy. Writing 0x8 to STATUS then reads overflow = 0.
REQ-034 Reset mid-frame: drop rst_n during DATA bit 3 -> tx = 1 in the same cycle, STATUS = 0x2 (empty). A following write of 0xA5 transmits correctly.
REQ-035 Wrap-around: 3 rounds of 4 bytes each, refilling after drain -> all 12 bytes received in order. full is asserted exactly when 4 bytes are queued.
REQ-036 With CONSOLE_UART_SIM_PRINT_EN defined: writing "Hello World\n" prints the same text. Undefined: nothing is printed and the tx waveform is identical.
